// File: rtl/linear_requantizer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | linear_requantizer_pkg                                                     |
// | Shared widths, typedefs and the signed saturation helper for the layer.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package linear_requantizer_pkg;

  localparam int unsigned C_PRECISION      = 8;
  localparam int unsigned C_BIAS_PRECISION = 32;
  localparam int unsigned C_MULT_PRECISION = 32;
  localparam int unsigned C_SHIFT_WIDTH    = 6;
  localparam int unsigned C_SAT_WIDTH      = 128;

  typedef logic signed [C_BIAS_PRECISION-1:0]                  acc_t;
  typedef logic        [C_PRECISION-1:0]                       act_t;
  typedef logic signed [C_MULT_PRECISION-1:0]                  mult_t;
  typedef logic signed [C_BIAS_PRECISION+C_MULT_PRECISION-1:0] prod_t;

  // Clamp a wide signed value into the signed range of 'width' bits.
  function automatic logic signed [C_SAT_WIDTH-1:0] sat_signed(
    input logic signed [C_SAT_WIDTH-1:0] value,
    input int unsigned                   width
  );
    logic signed [C_SAT_WIDTH-1:0] w_one;
    logic signed [C_SAT_WIDTH-1:0] w_max;
    logic signed [C_SAT_WIDTH-1:0] w_min;
    w_one = 1;
    w_max = (w_one <<< (width - 1)) - w_one;
    w_min = -w_max - w_one;
    if (value > w_max) begin
      return w_max;
    end else if (value < w_min) begin
      return w_min;
    end
    return value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/linear_requantizer_round_shift.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | linear_requantizer_round_shift                                             |
// | Registered arithmetic right shift, rounding half toward +infinity.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module linear_requantizer_round_shift #(
  parameter int unsigned IN_WIDTH    = 64,
  parameter int unsigned SHIFT_WIDTH = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_en,
  input  logic signed [IN_WIDTH-1:0] i_value,
  input  logic [SHIFT_WIDTH-1:0]     i_shift,
  output logic signed [IN_WIDTH:0]   o_result
);

  logic signed [IN_WIDTH:0] w_ext;
  logic signed [IN_WIDTH:0] w_half;
  logic signed [IN_WIDTH:0] w_sum;
  logic signed [IN_WIDTH:0] w_rounded;

  // One guard bit keeps value + half from wrapping at the largest shifts.
  assign w_ext     = {i_value[IN_WIDTH-1], i_value};
  assign w_half    = (i_shift == '0) ? '0
                   : ((IN_WIDTH+1)'(1) << (i_shift - SHIFT_WIDTH'(1)));
  assign w_sum     = w_ext + w_half;
  assign w_rounded = w_sum >>> i_shift;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_result <= '0;
    end else if (i_en) begin
      o_result <= w_rounded;
    end
  end

endmodule
`default_nettype wire

// File: rtl/linear_requantizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | linear_requantizer                                                         |
// | 4-stage requantization: zero-point removal, bias, scale, round, clamp.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module linear_requantizer
  import linear_requantizer_pkg::*;
#(
  parameter int unsigned PRECISION      = C_PRECISION,
  parameter int unsigned BIAS_PRECISION = C_BIAS_PRECISION,
  parameter int unsigned MULT_PRECISION = C_MULT_PRECISION,
  parameter int unsigned SHIFT_WIDTH    = C_SHIFT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BIAS_PRECISION-1:0] acc,
  input  logic [BIAS_PRECISION-1:0] ai,
  input  logic [BIAS_PRECISION-1:0] bias,
  input  logic [PRECISION-1:0]      zp_w,
  input  logic [MULT_PRECISION-1:0] mult,
  input  logic [SHIFT_WIDTH-1:0]    shift,
  input  logic [PRECISION-1:0]      zp_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PRECISION-1:0]      out_data,
  output logic                      busy
);

  localparam int unsigned C_CORR_W = BIAS_PRECISION + PRECISION + 2;
  localparam int unsigned C_PROD_W = BIAS_PRECISION + MULT_PRECISION;
  localparam int unsigned C_RND_W  = C_PROD_W + 1;
  localparam int unsigned C_Y_W    = C_RND_W + 1;

  logic [3:0]                          r_vld;
  logic                                w_en;
  logic                                w_in_fire;
  logic [PRECISION+BIAS_PRECISION-1:0] w_zpai;
  logic signed [C_CORR_W-1:0]          w_acc_ext;
  logic signed [C_CORR_W-1:0]          w_bias_ext;
  logic signed [C_CORR_W-1:0]          w_zpai_ext;
  logic signed [C_CORR_W-1:0]          w_corr_wide;
  logic signed [BIAS_PRECISION-1:0]    w_corr_sat;
  logic signed [BIAS_PRECISION-1:0]    r_corr;
  logic signed [C_PROD_W-1:0]          w_prod;
  logic signed [C_PROD_W-1:0]          r_prod;
  logic signed [C_RND_W-1:0]           w_rnd;
  logic signed [C_Y_W-1:0]             w_y;
  logic [PRECISION-1:0]                w_clamp;
  logic [PRECISION-1:0]                r_out;

  assign w_en      = !r_vld[3] || out_ready;
  assign in_ready  = w_en && rst;
  assign w_in_fire = in_valid && in_ready;
  assign out_valid = r_vld[3];
  assign out_data  = r_out;
  assign busy      = |r_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
    end else if (w_en) begin
      r_vld <= {r_vld[2:0], w_in_fire};
    end
  end

  // S1: unsigned zp_w*ai fits P+B bits; two extra bits hold the signed sum.
  assign w_zpai      = {{BIAS_PRECISION{1'b0}}, zp_w} * {{PRECISION{1'b0}}, ai};
  assign w_acc_ext   = {{(C_CORR_W-BIAS_PRECISION){acc[BIAS_PRECISION-1]}}, acc};
  assign w_bias_ext  = {{(C_CORR_W-BIAS_PRECISION){bias[BIAS_PRECISION-1]}}, bias};
  assign w_zpai_ext  = {2'b00, w_zpai};
  assign w_corr_wide = w_acc_ext + w_bias_ext - w_zpai_ext;
  assign w_corr_sat  = BIAS_PRECISION'(sat_signed(
                         {{(C_SAT_WIDTH-C_CORR_W){w_corr_wide[C_CORR_W-1]}}, w_corr_wide},
                         BIAS_PRECISION));

  // S2: full-width signed product.
  assign w_prod = $signed({{MULT_PRECISION{r_corr[BIAS_PRECISION-1]}}, r_corr})
                * $signed({{BIAS_PRECISION{mult[MULT_PRECISION-1]}}, mult});

  linear_requantizer_round_shift #(
    .IN_WIDTH    (C_PROD_W),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_round_shift (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_en && r_vld[1]),
    .i_value  (r_prod),
    .i_shift  (shift),
    .o_result (w_rnd)
  );

  // S4: add output zero-point, clamp into the unsigned activation range.
  assign w_y = {w_rnd[C_RND_W-1], w_rnd} + {{(C_Y_W-PRECISION){1'b0}}, zp_out};

  always_comb begin
    w_clamp = w_y[PRECISION-1:0];
    if (w_y[C_Y_W-1]) begin
      w_clamp = '0;
    end else if (|w_y[C_Y_W-2:PRECISION]) begin
      w_clamp = '1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_corr <= '0;
      r_prod <= '0;
      r_out  <= '0;
    end else if (w_en) begin
      if (w_in_fire) begin
        r_corr <= w_corr_sat;
      end
      if (r_vld[0]) begin
        r_prod <= w_prod;
      end
      if (r_vld[2]) begin
        r_out <= w_clamp;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_linear_requantizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_linear_requantizer                                                      |
// | Directed table, stall/reset sequences and randomized scoreboard checks.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_linear_requantizer;
  import linear_requantizer_pkg::*;

  localparam logic signed [31:0] C_HALF = 32'sh4000_0000;

  typedef struct {
    logic signed [31:0] acc;
    logic        [31:0] ai;
    logic signed [31:0] bias;
    logic        [7:0]  zp_w;
    logic signed [31:0] mult;
    logic        [5:0]  shift;
    logic        [7:0]  zp_out;
    logic        [7:0]  exp;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  acc_t               acc = '0;
  logic [31:0]        ai = '0;
  acc_t               bias = '0;
  act_t               zp_w = '0;
  mult_t              mult = C_HALF;
  logic [5:0]         shift = 6'd31;
  act_t               zp_out = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  act_t               out_data;
  logic               busy;

  int                 checks = 0;
  int                 errors = 0;
  act_t               exp_q[$];
  logic               s_in_fire;
  logic               s_out_valid;
  act_t               s_out_data;
  int                 n_out;
  logic               hold_valid = 1'b0;
  act_t               hold_data;
  vec_t               vecs[15];

  always #5 clk = ~clk;

  linear_requantizer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .acc       (acc),
    .ai        (ai),
    .bias      (bias),
    .zp_w      (zp_w),
    .mult      (mult),
    .shift     (shift),
    .zp_out    (zp_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // Reference: exact integer arithmetic with floor division for the rounding step.
  function automatic act_t ref_model(input logic signed [31:0] a, input logic [31:0] s_ai,
                                     input logic signed [31:0] b, input logic [7:0] zw,
                                     input logic signed [31:0] m, input logic [5:0] sh,
                                     input logic [7:0] zo);
    logic signed [127:0] corr, t1, t2, prod, num, den, q, y;
    corr = a;
    t1 = b;
    corr = corr + t1;
    t1 = s_ai;
    t2 = zw;
    corr = corr - t1 * t2;
    if (corr > 128'sd2147483647) corr = 128'sd2147483647;
    else if (corr < -128'sd2147483648) corr = -128'sd2147483648;
    t1 = m;
    prod = corr * t1;
    if (sh == 6'd0) begin
      q = prod;
    end else begin
      den = 128'sd1 <<< sh;
      num = prod + den / 2;
      q = num / den;
      if ((num % den) != 0 && num < 0) q = q - 1;
    end
    t1 = zo;
    y = q + t1;
    if (y < 0) return 8'd0;
    if (y > 255) return 8'd255;
    return y[7:0];
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle: observe handshakes at the falling edge, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    s_in_fire   = in_valid && in_ready;
    s_out_valid = out_valid;
    s_out_data  = out_data;
    if (!rst) begin
      exp_q.delete();
      hold_valid = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) check("unexpected_output", 1, 0);
        else check("scoreboard_data", out_data, exp_q.pop_front());
      end
      if (out_valid && !out_ready) begin
        if (hold_valid) check("stall_stable", out_data, hold_data);
        hold_valid = 1'b1;
        hold_data  = out_data;
      end else begin
        hold_valid = 1'b0;
      end
      if (s_in_fire) exp_q.push_back(ref_model(acc, ai, bias, zp_w, mult, shift, zp_out));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cfg(input int mode);
    zp_w   = 8'($urandom_range(0, 255));
    zp_out = 8'($urandom_range(0, 255));
    if (mode == 0) begin
      bias  = int'($urandom_range(0, 131072)) - 65536;
      mult  = 32'($urandom_range(32'h2000_0000, 32'h7FFF_FFFF));
      shift = 6'($urandom_range(28, 40));
    end else begin
      bias  = $urandom;
      mult  = 32'($urandom_range(1, 32'h7FFF_FFFF));
      shift = 6'($urandom_range(0, 63));
    end
  endtask

  task automatic rand_item(input int mode);
    if (mode == 0) begin
      acc = int'($urandom_range(0, 2097152)) - 1048576;
      ai  = $urandom_range(0, 65535);
    end else begin
      acc = $urandom;
      ai  = $urandom;
    end
  endtask

  initial begin
    int lat;
    int idx;
    int cyc;
    vecs[0]  = '{200, 0, 0, 0, C_HALF, 31, 0, 100};
    vecs[1]  = '{3, 0, 0, 0, C_HALF, 31, 0, 2};
    vecs[2]  = '{-3, 0, 0, 0, C_HALF, 31, 128, 127};
    vecs[3]  = '{500, 10, -100, 20, C_HALF, 31, 0, 100};
    vecs[4]  = '{2000, 0, 0, 0, C_HALF, 31, 0, 255};
    vecs[5]  = '{-2000, 0, 0, 0, C_HALF, 31, 0, 0};
    vecs[6]  = '{-1, 0, 0, 0, C_HALF, 31, 10, 10};
    vecs[7]  = '{1, 0, 0, 0, C_HALF, 31, 0, 1};
    vecs[8]  = '{2, 0, 0, 0, C_HALF, 31, 255, 255};
    vecs[9]  = '{77, 0, 0, 0, 1, 0, 0, 77};
    vecs[10] = '{32'sh7FFF_FFFF, 0, 32'sh7FFF_FFFF, 0, 1, 24, 0, 128};
    vecs[11] = '{32'sh8000_0000, 1000, 32'sh8000_0000, 255, 1, 24, 200, 72};
    vecs[12] = '{0, 32'hFFFF_FFFF, 0, 1, 1, 31, 5, 4};
    vecs[13] = '{100, 0, 0, 0, 32'sh7FFF_FFFF, 31, 0, 100};
    vecs[14] = '{32'sh7FFF_FFFF, 0, 0, 0, 32'sh7FFF_FFFF, 63, 3, 3};

    // Reset state
    n_out = 0;
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b1;
    tick();
    check("idle_in_ready", in_ready, 1);

    // Directed table: latency and value for single transfers
    for (int i = 0; i < 15; i++) begin
      acc = vecs[i].acc;   ai = vecs[i].ai;     bias = vecs[i].bias;
      zp_w = vecs[i].zp_w; mult = vecs[i].mult; shift = vecs[i].shift;
      zp_out = vecs[i].zp_out;
      in_valid = 1'b1;
      tick();
      check($sformatf("vec%0d_accept", i), s_in_fire, 1);
      in_valid = 1'b0;
      lat = 0;
      s_out_valid = 1'b0;
      while (!s_out_valid && lat < 12) begin
        tick();
        lat++;
      end
      check($sformatf("vec%0d_latency", i), lat, 4);
      check($sformatf("vec%0d_data", i), s_out_data, vecs[i].exp);
    end

    // Back-pressure: 6 items offered against a blocked output
    acc = 0; ai = 0; bias = 0; zp_w = 0; mult = C_HALF; shift = 6'd31; zp_out = 0;
    out_ready = 1'b0;
    idx = 0;
    n_out = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = (idx < 6);
      acc = 10 * (idx + 1);
      tick();
      if (s_in_fire) idx++;
    end
    check("stall_accepted", idx, 4);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    out_ready = 1'b1;
    cyc = 0;
    while ((idx < 6 || exp_q.size() != 0) && cyc < 40) begin
      in_valid = (idx < 6);
      acc = 10 * (idx + 1);
      tick();
      if (s_in_fire) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    check("stall_outputs", n_out, 6);
    check("stall_drain", exp_q.size(), 0);

    // Reset with three items in flight
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      acc = 40 + k;
      tick();
    end
    in_valid = 1'b0;
    check("midrst_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_data", out_data, 0);
    tick();
    rst = 1'b1;
    n_out = 0;
    repeat (10) tick();
    check("midrst_no_stale", n_out, 0);
    check("midrst_idle_busy", busy, 0);

    // Randomized batches with random bubbles and back-pressure
    for (int b = 0; b < 6; b++) begin
      int mode;
      mode = b % 2;
      cyc = 0;
      while (busy && cyc < 20) begin
        out_ready = 1'b1;
        tick();
        cyc++;
      end
      rand_cfg(mode);
      rand_item(mode);
      idx = 0;
      cyc = 0;
      while (idx < 50 && cyc < 2000) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
        if (s_in_fire) begin
          idx++;
          rand_item(mode);
        end
        cyc++;
      end
      check($sformatf("batch%0d_sent", b), idx, 50);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cyc = 0;
      while ((exp_q.size() != 0 || busy) && cyc < 50) begin
        tick();
        cyc++;
      end
      check($sformatf("batch%0d_drain", b), exp_q.size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
